vec_mac_engine: RTL and testbench



---
 rtl/vec_mac_pkg.sv | 28 ++
 rtl/vec_mac_lane.sv | 60 ++++++
 rtl/vec_mac_engine.sv | 190 +++++++++++++++++++
 tb/tb_vec_mac_engine.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_mac_pkg.sv
// Shared opcodes, FSM encoding and width helpers for the vector MAC engine.
package vec_mac_pkg;

  // Command opcodes
  localparam logic [2:0] OP_WR_W    = 3'b000;
  localparam logic [2:0] OP_WR_A    = 3'b001;
  localparam logic [2:0] OP_BCAST_A = 3'b010;
  localparam logic [2:0] OP_DOT     = 3'b011;
  localparam logic [2:0] OP_DOT_ACC = 3'b100;
  localparam logic [2:0] OP_CLR_ACC = 3'b101;
  localparam logic [2:0] OP_RD_ACC  = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  // Engine control states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL    = 2'd1,
    SUM    = 2'd2,
    RESULT = 2'd3
  } state_e;

  // Full-precision adder tree output width: one product plus one bit per level
  function automatic int unsigned tree_width(input int unsigned lanes,
                                             input int unsigned data_w);
    return 2 * data_w + $clog2(lanes);
  endfunction

endpackage

// File: rtl/vec_mac_lane.sv
// One MAC lane: weight/activation row storage and a registered multiplier.
module vec_mac_lane
  import vec_mac_pkg::*;
#(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned ROW_W  = $clog2(DEPTH),
  localparam int unsigned PROD_W = 2 * DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_w_we,
  input  logic              i_a_we,
  input  logic [ROW_W-1:0]  i_wr_row,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_mul_en,
  input  logic [ROW_W-1:0]  i_w_row,
  input  logic [ROW_W-1:0]  i_a_row,
  input  logic              i_signed,
  output logic [PROD_W-1:0] o_prod
);

  logic [DATA_W-1:0] r_w [DEPTH];
  logic [DATA_W-1:0] r_a [DEPTH];
  logic [PROD_W-1:0] r_prod;

  logic [DATA_W-1:0] w_w_sel;
  logic [DATA_W-1:0] w_a_sel;
  logic [PROD_W-1:0] w_w_ext;
  logic [PROD_W-1:0] w_a_ext;
  logic [PROD_W-1:0] w_prod;

  // Row select and operand extension; the low PROD_W bits of the extended
  // product are exact for both signed and unsigned operands
  always_comb begin
    w_w_sel = r_w[i_w_row];
    w_a_sel = r_a[i_a_row];
    w_w_ext = {{DATA_W{i_signed & w_w_sel[DATA_W-1]}}, w_w_sel};
    w_a_ext = {{DATA_W{i_signed & w_a_sel[DATA_W-1]}}, w_a_sel};
    w_prod  = PROD_W'(w_w_ext * w_a_ext);
  end

  // Row storage writes and product register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_w[i] <= '0;
        r_a[i] <= '0;
      end
      r_prod <= '0;
    end else begin
      if (i_w_we) r_w[i_wr_row] <= i_wr_data;
      if (i_a_we) r_a[i_wr_row] <= i_wr_data;
      if (i_mul_en) r_prod <= w_prod;
    end
  end

  assign o_prod = r_prod;

endmodule

// File: rtl/vec_mac_engine.sv
// Multi-lane dot-product engine with accumulator and valid/ready ports.
module vec_mac_engine
  import vec_mac_pkg::*;
#(
  parameter  int unsigned LANES  = 8,
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned DEPTH  = 4,
  parameter  int unsigned ACC_W  = 24,
  localparam int unsigned LANE_W = $clog2(LANES) + 1,
  localparam int unsigned ROW_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [LANE_W-1:0] cmd_lane,
  input  logic [ROW_W-1:0]  cmd_row,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              signed_mode,
  output logic              cmd_err,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned TREE_W = tree_width(LANES, DATA_W);
  localparam int unsigned LVLS   = $clog2(LANES);

  state_e r_state;
  state_e w_next_state;

  logic              r_cmd_ready;
  logic              r_res_valid;
  logic              r_cmd_err;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_res_data;
  logic [ROW_W-1:0]  r_w_row;
  logic [ROW_W-1:0]  r_a_row;
  logic              r_signed;
  logic              r_acc_mode;
  logic              r_rd_mode;

  logic              w_accept;
  logic              w_lane_ok;
  logic              w_err;
  logic [LANES-1:0]  w_w_we;
  logic [LANES-1:0]  w_a_we;
  logic [LANES-1:0][PROD_W-1:0] w_prod;
  logic [TREE_W-1:0] w_tree;
  logic [ACC_W-1:0]  w_sum_ext;
  logic [ACC_W-1:0]  w_acc_next;

  // Command decode: lane write enables and illegal-command detection
  always_comb begin
    w_accept  = cmd_valid & r_cmd_ready;
    w_lane_ok = (cmd_lane < LANE_W'(LANES));
    w_err     = 1'b0;
    w_w_we    = '0;
    w_a_we    = '0;
    if (w_accept) begin
      case (cmd_op)
        OP_WR_W: begin
          if (w_lane_ok) w_w_we[cmd_lane[LANE_W-2:0]] = 1'b1;
          else           w_err = 1'b1;
        end
        OP_WR_A: begin
          if (w_lane_ok) w_a_we[cmd_lane[LANE_W-2:0]] = 1'b1;
          else           w_err = 1'b1;
        end
        OP_BCAST_A: w_a_we = '1;
        OP_ILLEGAL: w_err  = 1'b1;
        default: ;
      endcase
    end
  end

  // Lane array
  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    vec_mac_lane #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .i_w_we    (w_w_we[g]),
      .i_a_we    (w_a_we[g]),
      .i_wr_row  (cmd_row),
      .i_wr_data (cmd_data),
      .i_mul_en  (r_state == MUL),
      .i_w_row   (r_w_row),
      .i_a_row   (r_a_row),
      .i_signed  (r_signed),
      .o_prod    (w_prod[g])
    );
  end

  // Pairwise adder tree over registered products, full precision throughout
  always_comb begin : p_tree
    logic [TREE_W-1:0] v_node [LANES];
    for (int i = 0; i < int'(LANES); i++) begin
      v_node[i] = {{LVLS{r_signed & w_prod[i][PROD_W-1]}}, w_prod[i]};
    end
    for (int l = 1; l <= int'(LVLS); l++) begin
      for (int i = 0; i < int'(LANES >> l); i++) begin
        v_node[i] = v_node[2*i] + v_node[2*i+1];
      end
    end
    w_tree = v_node[0];
  end

  // Extend tree sum to accumulator width and form the next accumulator value
  always_comb begin
    w_sum_ext  = r_signed ? ACC_W'($signed(w_tree)) : ACC_W'(w_tree);
    w_acc_next = r_acc_mode ? (r_acc + w_sum_ext) : w_sum_ext;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic; RD_ACC passes through SUM, which loads res_data from acc
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (cmd_op == OP_DOT || cmd_op == OP_DOT_ACC || cmd_op == OP_RD_ACC) begin
            w_next_state = (cmd_op == OP_RD_ACC) ? SUM : MUL;
          end
        end
      end
      MUL:    w_next_state = SUM;
      SUM:    w_next_state = RESULT;
      RESULT: if (res_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Registered handshake outputs, operand latches, accumulator and result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_ready <= 1'b1;
      r_res_valid <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_acc       <= '0;
      r_res_data  <= '0;
      r_w_row     <= '0;
      r_a_row     <= '0;
      r_signed    <= 1'b0;
      r_acc_mode  <= 1'b0;
      r_rd_mode   <= 1'b0;
    end else begin
      r_cmd_ready <= (w_next_state == IDLE);
      r_res_valid <= (w_next_state == RESULT);
      r_cmd_err   <= w_err;
      if (w_accept) begin
        case (cmd_op)
          OP_DOT, OP_DOT_ACC: begin
            r_w_row    <= cmd_row;
            r_a_row    <= cmd_data[ROW_W-1:0];
            r_signed   <= signed_mode;
            r_acc_mode <= (cmd_op == OP_DOT_ACC);
            r_rd_mode  <= 1'b0;
          end
          OP_RD_ACC:  r_rd_mode <= 1'b1;
          OP_CLR_ACC: r_acc     <= '0;
          default: ;
        endcase
      end
      if (r_state == SUM) begin
        if (r_rd_mode) begin
          r_res_data <= r_acc;
        end else begin
          r_acc      <= w_acc_next;
          r_res_data <= w_acc_next;
        end
      end
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign res_valid = r_res_valid;
  assign cmd_err   = r_cmd_err;
  assign res_data  = r_res_data;

endmodule

// File: tb/tb_vec_mac_engine.sv
// Scoreboard bench for vec_mac_engine at default parameters.
module tb_vec_mac_engine;
  import vec_mac_pkg::*;

  localparam int LANES = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_lane;
  logic [1:0]  cmd_row;
  logic [7:0]  cmd_data;
  logic        signed_mode;
  logic        cmd_err;
  logic        res_valid;
  logic        res_ready;
  logic [23:0] res_data;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [23:0] sb_q[$];
  logic [23:0] sb_exp;
  logic [7:0]  mw [LANES][DEPTH];
  logic [7:0]  ma [LANES][DEPTH];
  logic [23:0] macc;
  logic [23:0] got;
  logic [23:0] held;

  vec_mac_engine #(
    .LANES (8),
    .DATA_W(8),
    .DEPTH (4),
    .ACC_W (24)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_lane   (cmd_lane),
    .cmd_row    (cmd_row),
    .cmd_data   (cmd_data),
    .signed_mode(signed_mode),
    .cmd_err    (cmd_err),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [23:0] model_dot(input int wr, input int ar, input bit sm);
    int s;
    s = 0;
    for (int l = 0; l < LANES; l++) begin
      if (sm) s += int'($signed(mw[l][wr])) * int'($signed(ma[l][ar]));
      else    s += int'(mw[l][wr]) * int'(ma[l][ar]);
    end
    return s[23:0];
  endfunction

  task automatic model_reset();
    for (int l = 0; l < LANES; l++)
      for (int r = 0; r < DEPTH; r++) begin
        mw[l][r] = 8'h00;
        ma[l][r] = 8'h00;
      end
    macc = 24'h0;
  endtask

  // Offer one command, wait for acceptance, then update the reference model
  task automatic send(input logic [2:0] op, input logic [3:0] lane, input logic [1:0] row,
                      input logic [7:0] data, input logic sm);
    bit ok;
    int n;
    cmd_op = op; cmd_lane = lane; cmd_row = row; cmd_data = data;
    signed_mode = sm; cmd_valid = 1'b1;
    ok = 1'b0; n = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
      return;
    end
    case (op)
      OP_WR_W:    if (lane < 4'd8) mw[lane[2:0]][row] = data;
      OP_WR_A:    if (lane < 4'd8) ma[lane[2:0]][row] = data;
      OP_BCAST_A: for (int l = 0; l < LANES; l++) ma[l][row] = data;
      OP_DOT:     begin macc = model_dot(int'(row), int'(data[1:0]), sm); sb_q.push_back(macc); end
      OP_DOT_ACC: begin macc = macc + model_dot(int'(row), int'(data[1:0]), sm); sb_q.push_back(macc); end
      OP_CLR_ACC: macc = 24'h0;
      OP_RD_ACC:  sb_q.push_back(macc);
      default: ;
    endcase
  endtask

  // Issue a result-producing command, check latency, return the result value
  task automatic run_res(input logic [2:0] op, input logic [1:0] row, input logic [1:0] arow,
                         input logic sm, input int exp_lat, output logic [23:0] val);
    bit found;
    int lat;
    send(op, 4'd0, row, {6'b0, arow}, sm);
    signed_mode = ~sm;
    found = 1'b0; lat = 99; val = 24'hx;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (res_valid) begin
        found = 1'b1;
        lat = c;
        val = res_data;
      end
    end
    check_eq("latency", lat, exp_lat);
    @(posedge clk);
    #1;
    signed_mode = 1'b0;
  endtask

  // Scoreboard: compare every consumed result against the queued expectation
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected", 32'd1, 32'd0);
      end else begin
        sb_exp = sb_q.pop_front();
        check_eq("sb_res", res_data, sb_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] err_op   [4];
    logic [3:0] err_lane [4];
    logic       err_exp  [4];
    bit         found;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'b0; cmd_lane = 4'd0; cmd_row = 2'd0;
    cmd_data = 8'h0; signed_mode = 1'b0; res_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_cmd_ready", cmd_ready, 1);
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_cmd_err", cmd_err, 0);
    check_eq("rst_res_data", res_data, 0);
    @(posedge clk); #1;

    // Unsigned dot
    for (int l = 0; l < LANES; l++) send(OP_WR_W, 4'(l), 2'd0, 8'(l + 1), 1'b0);
    send(OP_BCAST_A, 4'd0, 2'd0, 8'd2, 1'b0);
    run_res(OP_DOT, 2'd0, 2'd0, 1'b0, 2, got);
    check_eq("udot", got, 24'd72);

    // Signed vs unsigned on the same rows
    for (int l = 0; l < LANES; l++) send(OP_WR_W, 4'(l), 2'd1, 8'hFF, 1'b0);
    send(OP_BCAST_A, 4'd0, 2'd1, 8'd127, 1'b0);
    run_res(OP_DOT, 2'd1, 2'd1, 1'b1, 2, got);
    check_eq("sdot", got, 24'hFFFC08);
    run_res(OP_DOT, 2'd1, 2'd1, 1'b0, 2, got);
    check_eq("udot_ff", got, 24'd259080);

    // Accumulate with modulo wrap, then read back
    for (int l = 0; l < LANES; l++) send(OP_WR_W, 4'(l), 2'd2, 8'hFF, 1'b0);
    send(OP_BCAST_A, 4'd0, 2'd2, 8'hFF, 1'b0);
    send(OP_CLR_ACC, 4'd0, 2'd0, 8'h0, 1'b0);
    repeat (33) run_res(OP_DOT_ACC, 2'd2, 2'd2, 1'b0, 2, got);
    check_eq("acc_wrap", got, 24'd389384);
    run_res(OP_RD_ACC, 2'd0, 2'd0, 1'b0, 1, got);
    check_eq("rd_acc", got, 24'd389384);
    send(OP_CLR_ACC, 4'd0, 2'd0, 8'h0, 1'b0);
    run_res(OP_RD_ACC, 2'd0, 2'd0, 1'b0, 1, got);
    check_eq("rd_clr", got, 24'd0);

    // Backpressure: result held, write command stalled until consumed
    send(OP_BCAST_A, 4'd0, 2'd3, 8'd1, 1'b0);
    res_ready = 1'b0;
    send(OP_DOT, 4'd0, 2'd0, 8'd0, 1'b0);
    cmd_op = OP_WR_W; cmd_lane = 4'd0; cmd_row = 2'd3; cmd_data = 8'h55; cmd_valid = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (res_valid) found = 1'b1;
    end
    check_eq("bp_valid_seen", found, 1);
    held = res_data;
    check_eq("bp_value", held, 24'd72);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("bp_hold", res_data, held);
      check_eq("bp_busy", cmd_ready, 0);
      check_eq("bp_valid", res_valid, 1);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("bp_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    mw[0][3] = 8'h55;
    run_res(OP_DOT, 2'd3, 2'd3, 1'b0, 2, got);
    check_eq("bp_wr", got, 24'd85);

    // Illegal commands pulse cmd_err for one cycle and change nothing
    err_op[0] = OP_WR_W;    err_lane[0] = 4'd9; err_exp[0] = 1'b1;
    err_op[1] = OP_WR_A;    err_lane[1] = 4'd8; err_exp[1] = 1'b1;
    err_op[2] = OP_ILLEGAL; err_lane[2] = 4'd0; err_exp[2] = 1'b1;
    err_op[3] = OP_WR_W;    err_lane[3] = 4'd7; err_exp[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(err_op[i], err_lane[i], (i == 3) ? 2'd3 : 2'd0, (i == 3) ? 8'h00 : 8'hAA, 1'b0);
      @(negedge clk);
      check_eq("err_pulse", cmd_err, err_exp[i]);
      @(negedge clk);
      check_eq("err_clear", cmd_err, 0);
      @(posedge clk); #1;
    end
    run_res(OP_DOT, 2'd0, 2'd0, 1'b0, 2, got);
    check_eq("err_dot", got, 24'd72);

    // Reset while a DOT is in MUL: result lost, everything cleared
    send(OP_DOT, 4'd0, 2'd0, 8'd0, 1'b0);
    rst = 1'b1;
    sb_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_valid", res_valid, 0);
    check_eq("mid_rst_ready", cmd_ready, 1);
    check_eq("mid_rst_data", res_data, 0);
    @(posedge clk); #1;
    run_res(OP_RD_ACC, 2'd0, 2'd0, 1'b0, 1, got);
    check_eq("mid_rst_acc", got, 24'd0);
    run_res(OP_DOT, 2'd0, 2'd0, 1'b0, 2, got);
    check_eq("mid_rst_dot0", got, 24'd0);
    run_res(OP_DOT, 2'd1, 2'd1, 1'b1, 2, got);
    check_eq("mid_rst_dot1", got, 24'd0);

    repeat (2) @(posedge clk);
    check_eq("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
